// File: rtl/ppfifo_sc_pkg.sv
// Shared encodings for the single-clock ping-pong FIFO: bank lifecycle and read-side sequencing.
// No logic lives here; widths and bank count are fixed by the ping-pong interface.
package ppfifo_sc_pkg;

    localparam int NUM_BANKS  = 2;
    localparam int SIZE_WIDTH = 24;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    // Read side: wait for a FULL bank, present it, then drain it.
    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_OFFER = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/ppfifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable; 1-cycle read latency.
// No backpressure; the read register holds its value whenever rd_en is low.
module ppfifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ppfifo_sc.sv
// Two-bank ping-pong FIFO provider; commit-to-offer 2 cycles, read strobe to next word 1 cycle.
// Producer is throttled by o_wr_rdy per bank; excess writes are dropped and flagged in o_overflow.
module ppfifo_sc
    import ppfifo_sc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [1:0]            o_wr_rdy,
    input  logic [1:0]            i_wr_act,
    output logic [23:0]           o_wr_size,
    input  logic                  i_wr_stb,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_rd_rdy,
    input  logic                  i_rd_act,
    output logic [23:0]           o_rd_size,
    input  logic                  i_rd_stb,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_idle,
    output logic                  o_overflow
);

    localparam logic [ADDR_WIDTH:0] BANK_WORDS = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

    bank_state_t           bank_q [NUM_BANKS];
    bank_state_t           bank_d [NUM_BANKS];
    logic [ADDR_WIDTH:0]   cnt_q  [NUM_BANKS];
    logic [ADDR_WIDTH:0]   cnt_d  [NUM_BANKS];
    logic                  older_q, older_d;
    logic [1:0]            wr_act_q;
    logic [1:0]            act_rise, act_fall;
    logic                  overflow_q, overflow_d;
    logic [1:0]            wr_rdy_q;

    rd_state_t             rd_q, rd_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   ptr_inc;
    logic [SIZE_WIDTH-1:0] rd_size_q, rd_size_d;

    logic                  sel_vld;
    logic                  sel_bank;

    logic                  ram_wr_en;
    logic [ADDR_WIDTH:0]   ram_wr_addr;
    logic                  ram_rd_en;
    logic [ADDR_WIDTH:0]   ram_rd_addr;

    assign act_rise = i_wr_act & ~wr_act_q;
    assign act_fall = ~i_wr_act & wr_act_q;
    assign ptr_inc  = {1'b0, ptr_q} + (ADDR_WIDTH+1)'(1);

    // Oldest FULL bank wins when both are waiting.
    assign sel_vld  = (bank_q[0] == BANK_FULL) || (bank_q[1] == BANK_FULL);
    assign sel_bank = ((bank_q[0] == BANK_FULL) && (bank_q[1] == BANK_FULL)) ? older_q
                                                                               : (bank_q[1] == BANK_FULL);

    always_comb begin
        for (int k = 0; k < NUM_BANKS; k++) begin
            bank_d[k] = bank_q[k];
            cnt_d[k]  = cnt_q[k];
        end
        older_d     = older_q;
        overflow_d  = overflow_q;
        ram_wr_en   = 1'b0;
        ram_wr_addr = '0;
        rd_d        = rd_q;
        rd_bank_d   = rd_bank_q;
        ptr_d       = ptr_q;
        rd_size_d   = rd_size_q;
        ram_rd_en   = 1'b0;
        ram_rd_addr = {rd_bank_q, ptr_q};

        for (int k = 0; k < NUM_BANKS; k++) begin
            if (bank_q[k] == BANK_EMPTY) begin
                if (act_rise[k] && (i_wr_act != 2'b11)) begin
                    bank_d[k] = BANK_FILLING;
                    cnt_d[k]  = '0;
                end
            end else if (bank_q[k] == BANK_FILLING) begin
                if (act_fall[k]) begin
                    if (cnt_q[k] != '0) begin
                        bank_d[k] = BANK_FULL;
                        // If the other bank is already waiting it stays the older one.
                        if (((k == 0) ? bank_q[1] : bank_q[0]) != BANK_FULL) begin
                            older_d = k[0];
                        end
                    end else begin
                        bank_d[k] = BANK_EMPTY;
                    end
                end else if (i_wr_stb && i_wr_act[k]) begin
                    if (cnt_q[k] == BANK_WORDS) begin
                        overflow_d = 1'b1;
                    end else begin
                        ram_wr_en   = 1'b1;
                        ram_wr_addr = {k[0], cnt_q[k][ADDR_WIDTH-1:0]};
                        cnt_d[k]    = cnt_q[k] + (ADDR_WIDTH+1)'(1);
                    end
                end
            end
        end

        case (rd_q)
            RD_IDLE: begin
                if (sel_vld) begin
                    ram_rd_en   = 1'b1;
                    ram_rd_addr = {sel_bank, {ADDR_WIDTH{1'b0}}};
                    rd_bank_d   = sel_bank;
                    ptr_d       = '0;
                    rd_size_d   = SIZE_WIDTH'(cnt_q[sel_bank]);
                    rd_d        = RD_OFFER;
                end
            end
            RD_OFFER: begin
                if (i_rd_act) begin
                    bank_d[rd_bank_q] = BANK_DRAINING;
                    rd_d              = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (!i_rd_act) begin
                    bank_d[rd_bank_q] = BANK_EMPTY;
                    cnt_d[rd_bank_q]  = '0;
                    ptr_d             = '0;
                    rd_size_d         = '0;
                    rd_d              = RD_IDLE;
                end else if (i_rd_stb && (ptr_inc < cnt_q[rd_bank_q])) begin
                    // Read one ahead so the output register already holds the next word.
                    ptr_d       = ptr_inc[ADDR_WIDTH-1:0];
                    ram_rd_en   = 1'b1;
                    ram_rd_addr = {rd_bank_q, ptr_inc[ADDR_WIDTH-1:0]};
                end
            end
            default: begin
                rd_d = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                bank_q[k] <= BANK_EMPTY;
                cnt_q[k]  <= '0;
            end
            older_q    <= 1'b0;
            wr_act_q   <= 2'b00;
            overflow_q <= 1'b0;
            wr_rdy_q   <= 2'b00;
            rd_q       <= RD_IDLE;
            rd_bank_q  <= 1'b0;
            ptr_q      <= '0;
            rd_size_q  <= '0;
        end else begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                bank_q[k] <= bank_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
            older_q    <= older_d;
            wr_act_q   <= i_wr_act;
            overflow_q <= overflow_d;
            wr_rdy_q   <= {bank_d[1] == BANK_EMPTY, bank_d[0] == BANK_EMPTY};
            rd_q       <= rd_d;
            rd_bank_q  <= rd_bank_d;
            ptr_q      <= ptr_d;
            rd_size_q  <= rd_size_d;
        end
    end

    ppfifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH + 1)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (i_wr_data),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (o_rd_data)
    );

    assign o_wr_rdy   = wr_rdy_q;
    assign o_wr_size  = SIZE_WIDTH'(2**ADDR_WIDTH);
    assign o_rd_rdy   = (rd_q == RD_OFFER);
    assign o_rd_size  = rd_size_q;
    assign o_overflow = overflow_q;
    assign o_idle     = (bank_q[0] == BANK_EMPTY) && (bank_q[1] == BANK_EMPTY) && (i_wr_act == 2'b00);

endmodule

// File: tb/tb_ppfifo_sc.sv
// Directed bench for ppfifo_sc with 16-word banks; written words and committed sizes feed a scoreboard.
module tb_ppfifo_sc;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wr_rdy;
    logic [1:0]  wr_act;
    logic [23:0] wr_size;
    logic        wr_stb;
    logic [31:0] wr_data;
    logic        rd_rdy;
    logic        rd_act;
    logic [23:0] rd_size;
    logic        rd_stb;
    logic [31:0] rd_data;
    logic        idle;
    logic        overflow;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    int          size_q[$];
    logic [31:0] w;

    always #5 clk = ~clk;

    ppfifo_sc #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .o_wr_rdy   (wr_rdy),
        .i_wr_act   (wr_act),
        .o_wr_size  (wr_size),
        .i_wr_stb   (wr_stb),
        .i_wr_data  (wr_data),
        .o_rd_rdy   (rd_rdy),
        .i_rd_act   (rd_act),
        .o_rd_size  (rd_size),
        .i_rd_stb   (rd_stb),
        .o_rd_data  (rd_data),
        .o_idle     (idle),
        .o_overflow (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, output logic [31:0] e);
        if (exp_q.size() == 0) begin
            e = '0;
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, rd_data);
        end else begin
            e = exp_q.pop_front();
            chk(tag, rd_data, e);
        end
    endtask

    // Claim bank k, write n words base.., then commit. Returns one cycle after the commit edge.
    task automatic write_bank(input int k, input int n, input int base);
        wr_act    = 2'b00;
        wr_act[k] = 1'b1;
        tick();
        chk("wr_rdy_claim", {31'd0, wr_rdy[k]}, 32'd0);
        for (int i = 0; i < n; i++) begin
            wr_stb  = 1'b1;
            wr_data = base + i;
            if (i < 16) exp_q.push_back(base + i);
            tick();
        end
        wr_stb = 1'b0;
        wr_act = 2'b00;
        tick();
        if (n > 0) size_q.push_back((n > 16) ? 16 : n);
    endtask

    task automatic wait_offer();
        for (int i = 0; i < 16 && rd_rdy !== 1'b1; i++) tick();
        chk("rd_rdy_offer", {31'd0, rd_rdy}, 32'd1);
    endtask

    // Take the offered bank k, issue nstb strobes, then release it.
    task automatic read_bank(input int k, input int nstb);
        int          sz;
        int          shown;
        logic [31:0] last;
        wait_offer();
        sz = (size_q.size() > 0) ? size_q.pop_front() : 0;
        chk("rd_size", {8'd0, rd_size}, sz);
        pop_chk("rd_word0", last);
        shown  = 1;
        rd_act = 1'b1;
        tick();
        chk("rd_rdy_clear", {31'd0, rd_rdy}, 32'd0);
        for (int i = 0; i < nstb; i++) begin
            rd_stb = 1'b1;
            tick();
            if (shown < sz) begin
                pop_chk("rd_word", last);
                shown++;
            end else begin
                chk("rd_hold", rd_data, last);
            end
        end
        rd_stb = 1'b0;
        for (int i = shown; i < sz; i++) void'(exp_q.pop_front());
        rd_act = 1'b0;
        tick();
        chk("wr_rdy_release", {31'd0, wr_rdy[k]}, 32'd1);
    endtask

    initial begin
        rst     = 1'b1;
        wr_act  = 2'b00;
        wr_stb  = 1'b0;
        wr_data = '0;
        rd_act  = 1'b0;
        rd_stb  = 1'b0;
        tick();
        tick();
        chk("rst_wr_rdy", {30'd0, wr_rdy}, 32'd0);
        chk("rst_rd_rdy", {31'd0, rd_rdy}, 32'd0);
        chk("rst_rd_size", {8'd0, rd_size}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("wr_size", {8'd0, wr_size}, 32'd16);
        rst = 1'b0;
        tick();
        chk("wr_rdy_after_rst", {30'd0, wr_rdy}, 32'd3);

        // Both claims at once are ignored.
        wr_act = 2'b11;
        tick();
        chk("act11_ignored", {30'd0, wr_rdy}, 32'd3);
        wr_act = 2'b00;
        tick();
        chk("act11_no_offer", {31'd0, rd_rdy}, 32'd0);

        // Full bank 0, offer two cycles after commit, sixteen strobes.
        write_bank(0, 16, 0);
        chk("offer_t1", {31'd0, rd_rdy}, 32'd0);
        tick();
        chk("offer_t2", {31'd0, rd_rdy}, 32'd1);
        read_bank(0, 16);

        // Commit order: bank 1 first, then bank 0.
        write_bank(1, 3, 32'h100);
        write_bank(0, 5, 32'h200);
        chk("idle_busy", {31'd0, idle}, 32'd0);
        read_bank(1, 3);
        chk("offer_rel_t1", {31'd0, rd_rdy}, 32'd0);
        tick();
        chk("offer_rel_t2", {31'd0, rd_rdy}, 32'd1);
        chk("offer_rel_size", {8'd0, rd_size}, 32'd5);
        read_bank(0, 5);

        // Zero-length commit of bank 1.
        write_bank(1, 0, 0);
        chk("zero_wr_rdy", {31'd0, wr_rdy[1]}, 32'd1);
        chk("zero_rd_rdy", {31'd0, rd_rdy}, 32'd0);
        tick();
        tick();
        chk("zero_rd_rdy_late", {31'd0, rd_rdy}, 32'd0);

        // Overflow: 18 strobes into a 16-word bank.
        chk("ovf_before", {31'd0, overflow}, 32'd0);
        write_bank(0, 18, 32'h300);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        read_bank(0, 16);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Partial read: 4 of 10 words, remainder discarded.
        write_bank(0, 10, 32'h400);
        read_bank(0, 3);
        chk("partial_idle", {31'd0, idle}, 32'd1);
        chk("partial_wr_rdy", {30'd0, wr_rdy}, 32'd3);
        tick();
        tick();
        chk("partial_no_reoffer", {31'd0, rd_rdy}, 32'd0);

        // Reset while bank 1 drains and bank 0 fills.
        write_bank(1, 4, 32'h500);
        wait_offer();
        chk("mid_size", {8'd0, rd_size}, (size_q.size() > 0) ? size_q.pop_front() : 0);
        pop_chk("mid_word0", w);
        rd_act = 1'b1;
        tick();
        rd_stb = 1'b1;
        tick();
        pop_chk("mid_word1", w);
        rd_stb = 1'b0;
        wr_act = 2'b01;
        tick();
        chk("mid_claim", {31'd0, wr_rdy[0]}, 32'd0);
        wr_stb  = 1'b1;
        wr_data = 32'h600;
        tick();
        tick();
        wr_stb = 1'b0;
        rst    = 1'b1;
        wr_act = 2'b00;
        rd_act = 1'b0;
        tick();
        exp_q.delete();
        size_q.delete();
        chk("mrst_wr_rdy", {30'd0, wr_rdy}, 32'd0);
        chk("mrst_rd_rdy", {31'd0, rd_rdy}, 32'd0);
        chk("mrst_rd_size", {8'd0, rd_size}, 32'd0);
        chk("mrst_rd_data", rd_data, 32'd0);
        chk("mrst_overflow", {31'd0, overflow}, 32'd0);
        chk("mrst_idle", {31'd0, idle}, 32'd1);
        rst = 1'b0;
        tick();
        chk("mrst_wr_rdy_after", {30'd0, wr_rdy}, 32'd3);
        tick();
        chk("mrst_no_offer", {31'd0, rd_rdy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
